cache_fill_fsm: RTL and testbench

- Miss-handling engine that sits between the single-cycle core's cache arrays and the multi-cycle main memory.
- On a cache miss it fetches the 16-byte block containing the miss address as 8 word reads, issued back-to-back.
- It streams each returned word into the cache data array, then pulses a tag-array write when the block is complete.
- The core stalls while fsm_busy is high; the I-cache and D-cache each get one instance.

---
 rtl/cache_fill_fsm.sv | 115 +++++++++++
 tb/tb_cache_fill_fsm.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : cache_fill_fsm
//  Description : Cache miss fill engine. On a miss it issues one word read
//                per cycle for every word of the missing block. It streams
//                returned words into the data array in arrival order, then
//                pulses a tag-array write together with the final word.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_fsm #(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int OFFSET_W        = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                miss_detected,
  input  logic [ADDR_W-1:0]   miss_address,
  output logic                fsm_busy,
  output logic                mem_read,
  output logic [ADDR_W-1:0]   memory_address,
  input  logic [15:0]         memory_data,
  input  logic                memory_data_valid,
  output logic                write_data_array,
  output logic [OFFSET_W-1:0] data_array_offset,
  output logic [15:0]         data_array_wdata,
  output logic                write_tag_array,
  output logic [ADDR_W-1:0]   block_base
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  // Byte-offset bits inside a block (16-bit words, so one more than OFFSET_W)
  localparam int BLK_LSB = OFFSET_W + 1;
  localparam int WPB_M1  = WORDS_PER_BLOCK - 1;
  localparam logic [OFFSET_W:0]   ISSUE_DONE = WORDS_PER_BLOCK[OFFSET_W:0];
  localparam logic [OFFSET_W-1:0] RECV_LAST  = WPB_M1[OFFSET_W-1:0];

  logic [0:0]          state_q, state_d;
  logic [ADDR_W-1:0]   block_base_q, block_base_d;
  logic [OFFSET_W:0]   issue_cnt_q, issue_cnt_d;
  logic [OFFSET_W-1:0] recv_cnt_q, recv_cnt_d;

  logic                in_fill;
  logic [OFFSET_W-1:0] issue_idx;

  // Output decode: everything is a function of the current state and counters
  always_comb begin
    in_fill = (state_q == ST_FILL);
    // Once all requests are out, issue_cnt sits at WORDS_PER_BLOCK; clamp the
    // index so the address holds the last word instead of folding back to 0.
    issue_idx         = issue_cnt_q[OFFSET_W] ? '1 : issue_cnt_q[OFFSET_W-1:0];
    fsm_busy          = in_fill;
    mem_read          = in_fill && (issue_cnt_q < ISSUE_DONE);
    // block_base has its low BLK_LSB bits clear, so this add stays in-block
    memory_address    = block_base_q +
                        {{(ADDR_W-OFFSET_W-1){1'b0}}, issue_idx, 1'b0};
    write_data_array  = in_fill && memory_data_valid;
    data_array_offset = recv_cnt_q;
    data_array_wdata  = memory_data;
    write_tag_array   = in_fill && memory_data_valid && (recv_cnt_q == RECV_LAST);
    block_base        = block_base_q;
  end

  // Next-state logic: latch the block on a miss, count requests and responses
  always_comb begin
    state_d      = state_q;
    block_base_d = block_base_q;
    issue_cnt_d  = issue_cnt_q;
    recv_cnt_d   = recv_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_detected) begin
          state_d      = ST_FILL;
          block_base_d = {miss_address[ADDR_W-1:BLK_LSB], {BLK_LSB{1'b0}}};
          issue_cnt_d  = '0;
          recv_cnt_d   = '0;
        end
      end
      ST_FILL: begin
        if (mem_read) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        // Responses are counted, not matched: memory returns them in order
        if (memory_data_valid) begin
          recv_cnt_d = recv_cnt_q + 1'b1;
        end
        if (write_tag_array) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset; reset abandons any fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      block_base_q <= '0;
      issue_cnt_q  <= '0;
      recv_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      block_base_q <= block_base_d;
      issue_cnt_q  <= issue_cnt_d;
      recv_cnt_q   <= recv_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_fill_fsm
//  Description : Self-checking bench for cache_fill_fsm. A latency-modelled
//                memory with random stalls answers the fill requests. A
//                queue-based reference model predicts every output cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_fill_fsm;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        mem_read;
  logic [15:0] memory_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        write_data_array;
  logic [2:0]  data_array_offset;
  logic [15:0] data_array_wdata;
  logic        write_tag_array;
  logic [15:0] block_base;

  cache_fill_fsm #(.ADDR_W(16), .WORDS_PER_BLOCK(8), .OFFSET_W(3)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .mem_read          (mem_read),
    .memory_address    (memory_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .write_data_array  (write_data_array),
    .data_array_offset (data_array_offset),
    .data_array_wdata  (data_array_wdata),
    .write_tag_array   (write_tag_array),
    .block_base        (block_base)
  );

  always #5 clk = ~clk;

  // Memory: backing image plus an in-order queue of outstanding requests
  typedef struct {
    logic [15:0] addr;
    int          due;
  } req_t;
  logic [15:0] mem_img [0:32767];
  req_t        mem_q[$];
  int          min_gap;
  bit          stall_en;
  bit          noise_en;
  int          idle_run;

  // Reference model: a fill is a list of request addresses and write offsets
  bit          m_busy;
  logic [15:0] m_base;
  logic [15:0] exp_req[$];
  int          exp_off[$];
  int          m_writes;

  int          cyc;
  int          busy_cycles;
  logic [15:0] last_addr;
  int          errors;
  int          checks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive memory, check outputs, advance model past the edge
  task automatic do_cycle();
    bit          exp_rd;
    bit          exp_wr;
    logic [15:0] ea;
    memory_data_valid = 1'b0;
    memory_data       = 16'($urandom);
    if (noise_en && !m_busy) begin
      memory_data_valid = 1'($urandom_range(0, 1));
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc && idle_run >= min_gap &&
                 !(stall_en && $urandom_range(0, 2) == 0)) begin
      memory_data_valid = 1'b1;
      memory_data       = mem_img[mem_q[0].addr[15:1]];
      mem_q.delete(0);
    end
    if (memory_data_valid) idle_run = 0; else idle_run++;
    #1;
    exp_rd = m_busy && (exp_req.size() > 0);
    exp_wr = m_busy && memory_data_valid;
    if (m_busy) busy_cycles++;
    chk("busy", 32'(fsm_busy), 32'(m_busy));
    chk("mem_read", 32'(mem_read), 32'(exp_rd));
    if (exp_rd) chk("mem_addr", 32'(memory_address), 32'(exp_req[0]));
    if (m_busy && !exp_rd) chk("addr_hold", 32'(memory_address), 32'(m_base + 16'd14));
    chk("wr_data", 32'(write_data_array), 32'(exp_wr));
    chk("wr_tag", 32'(write_tag_array), 32'(exp_wr && exp_off.size() == 1));
    if (exp_wr && exp_off.size() > 0) begin
      ea = m_base + 16'(2 * exp_off[0]);
      chk("offset", 32'(data_array_offset), 32'(exp_off[0]));
      chk("wdata", 32'(data_array_wdata), 32'(mem_img[ea[15:1]]));
    end
    if (m_busy) chk("base", 32'(block_base), 32'(m_base));
    if (mem_read) begin
      mem_q.push_back('{memory_address, cyc + LAT});
      last_addr = memory_address;
    end
    if (m_busy) begin
      if (exp_rd) exp_req.delete(0);
      if (exp_wr) begin
        m_writes++;
        exp_off.delete(0);
        if (exp_off.size() == 0) m_busy = 1'b0;
      end
    end else if (miss_detected) begin
      m_busy   = 1'b1;
      m_base   = miss_address & 16'hFFF0;
      m_writes = 0;
      exp_req.delete();
      exp_off.delete();
      for (int k = 0; k < 8; k++) begin
        exp_req.push_back(m_base + 16'(2 * k));
        exp_off.push_back(k);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    miss_detected = 1'b0;
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  // Run one whole fill; hold keeps the miss asserted into the next IDLE cycle
  task automatic run_fill(input logic [15:0] addr, input bit hold, input bit chg);
    bit started = 1'b0;
    bit done    = 1'b0;
    miss_detected = 1'b1;
    miss_address  = addr;
    busy_cycles   = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (chg && busy_cycles == 3) miss_address = 16'h4000;
      do_cycle();
      if (m_busy) started = 1'b1;
      else if (started) done = 1'b1;
    end
    if (!hold) miss_detected = 1'b0;
    chk("fill_done", 32'(done), 32'd1);
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    rst_n = 1'b0; miss_detected = 1'b0; miss_address = 16'h0;
    memory_data = 16'h0; memory_data_valid = 1'b0;
    min_gap = 0; stall_en = 1'b0; noise_en = 1'b0; idle_run = 100;
    m_busy = 1'b0; m_base = 16'h0; m_writes = 0; last_addr = 16'h0;
    for (int i = 0; i < 32768; i++) mem_img[i] = 16'($urandom);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(fsm_busy), 32'd0);
    chk("rst_read", 32'(mem_read), 32'd0);
    chk("rst_addr", 32'(memory_address), 32'd0);
    chk("rst_base", 32'(block_base), 32'd0);
    chk("rst_tag", 32'(write_tag_array), 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Basic fill with a fixed 4-cycle memory
    run_fill(16'h1234, 1'b0, 1'b0);
    chk("basic_busy_len", 32'(busy_cycles), 32'd12);
    chk("basic_last_addr", 32'(last_addr), 32'h123E);
    idle_cycles(2);

    // Top of memory: no wrap past 0xFFFE
    run_fill(16'hFFFB, 1'b0, 1'b0);
    chk("top_last_addr", 32'(last_addr), 32'hFFFE);
    idle_cycles(2);

    // Two idle cycles between every response
    min_gap = 2;
    run_fill(16'h0A5E, 1'b0, 1'b0);
    min_gap = 0;
    idle_cycles(2);

    // Idle noise on memory_data_valid, then a fill with a mid-fill address change
    noise_en = 1'b1;
    idle_cycles(12);
    noise_en = 1'b0;
    run_fill(16'h3377, 1'b0, 1'b1);
    idle_cycles(2);

    // Reset after the third data write, then stray responses while idle
    miss_detected = 1'b1;
    miss_address  = 16'h5552;
    for (int i = 0; i < 60 && !(m_busy && m_writes == 3); i++) do_cycle();
    chk("rst_mid_writes", 32'(m_writes), 32'd3);
    miss_detected = 1'b0;
    memory_data_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(fsm_busy), 32'd0);
    chk("arst_read", 32'(mem_read), 32'd0);
    chk("arst_wr", 32'(write_data_array), 32'd0);
    chk("arst_tag", 32'(write_tag_array), 32'd0);
    chk("arst_addr", 32'(memory_address), 32'd0);
    chk("arst_off", 32'(data_array_offset), 32'd0);
    chk("arst_base", 32'(block_base), 32'd0);
    m_busy = 1'b0; m_base = 16'h0;
    exp_req.delete(); exp_off.delete();
    #3;
    rst_n = 1'b1;
    idle_cycles(10);
    mem_q.delete();

    // Back-to-back: miss stays high across completion with a new address
    run_fill(16'h1111, 1'b1, 1'b0);
    run_fill(16'h2000, 1'b0, 1'b0);
    idle_cycles(2);

    // Random addresses with random stalls
    for (int t = 0; t < 5; t++) begin
      min_gap  = $urandom_range(0, 1);
      stall_en = 1'($urandom_range(0, 1));
      run_fill(16'($urandom), 1'b0, 1'b0);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
